// File: rtl/vga_scan.sv
// 640x480@60 raster generator: broadcasts the upcoming pixel coordinate to the object
// modules and composites their hit flags into registered sync, blank and RGB outputs.
module vga_scan #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       hit_ball_i,
   input  logic       hit_bar_i,
   input  logic       hit_brick_i,
   output logic [9:0] next_x_o,
   output logic [9:0] next_y_o,
   output logic       vga_clk_o,
   output logic       vga_hs_o,
   output logic       vga_vs_o,
   output logic       vga_blank_n_o,
   output logic [7:0] vga_r_o,
   output logic [7:0] vga_g_o,
   output logic [7:0] vga_b_o,
   output logic       frame_pulse_o
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
   localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HVis    = 10'(H_VISIBLE);
   localparam logic [9:0] VVis    = 10'(V_VISIBLE);
   localparam logic [9:0] HsFirst = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HsLast  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VsFirst = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VsLast  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic        pix_en_q;
   logic [9:0]  h_cnt_q, v_cnt_q;
   logic [9:0]  nh, nv;
   logic        visible;
   logic [23:0] rgb_d;
   logic        hs_d, vs_d;

   logic        hs_q, vs_q, blank_n_q, frame_q;
   logic [23:0] rgb_q;

   always_comb begin
      nh = (h_cnt_q == HLast) ? 10'd0 : h_cnt_q + 10'd1;
      nv = v_cnt_q;
      if (h_cnt_q == HLast) begin
         nv = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
      end
      visible = (nh < HVis) && (nv < VVis);
      hs_d    = !((nh >= HsFirst) && (nh <= HsLast));
      vs_d    = !((nv >= VsFirst) && (nv <= VsLast));
      // Priority: ball over bar over brick; blanking forces black regardless of hits.
      rgb_d = 24'h000000;
      if (visible) begin
         if (hit_ball_i)       rgb_d = 24'hFFFFFF;
         else if (hit_bar_i)   rgb_d = 24'h00FFFF;
         else if (hit_brick_i) rgb_d = 24'hFF8000;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pix_en_q  <= 1'b0;
         h_cnt_q   <= HLast;
         v_cnt_q   <= VLast;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         rgb_q     <= 24'h000000;
         frame_q   <= 1'b0;
      end else begin
         pix_en_q <= ~pix_en_q;
         frame_q  <= 1'b0;
         if (pix_en_q) begin
            h_cnt_q   <= nh;
            v_cnt_q   <= nv;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= visible;
            rgb_q     <= rgb_d;
            frame_q   <= (nh == 10'd0) && (nv == 10'd0);
         end
      end
   end

   assign next_x_o      = nh;
   assign next_y_o      = nv;
   // Ticks happen as pix_en falls, so the DAC's rising vga_clk lands mid-pixel.
   assign vga_clk_o     = pix_en_q;
   assign vga_hs_o      = hs_q;
   assign vga_vs_o      = vs_q;
   assign vga_blank_n_o = blank_n_q;
   assign vga_r_o       = rgb_q[23:16];
   assign vga_g_o       = rgb_q[15:8];
   assign vga_b_o       = rgb_q[7:0];
   assign frame_pulse_o = frame_q;

endmodule

// File: tb/tb_vga_scan.sv
// Scoreboard bench for vga_scan: a full-size instance and a shrunken-timing instance run
// side by side against a pixel-index reference model driven by randomized hit scenes.
module tb_vga_scan;

   logic clock;
   logic reset;
   int   mode;
   logic [2:0] tab [256];

   logic [9:0] nx [2];
   logic [9:0] ny [2];
   logic       vclk [2], hs [2], vs [2], bl [2], fp [2];
   logic [7:0] rr [2], gg [2], bb [2];
   logic [2:0] hit [2];

   typedef struct packed {
      logic        rst;
      logic [48:0] v;
   } exp_t;

   exp_t q0 [$];
   exp_t q1 [$];

   int total = 0;
   int bad   = 0;

   vga_scan u_full (
      .clock        (clock),
      .reset        (reset),
      .hit_ball_i   (hit[0][2]),
      .hit_bar_i    (hit[0][1]),
      .hit_brick_i  (hit[0][0]),
      .next_x_o     (nx[0]),
      .next_y_o     (ny[0]),
      .vga_clk_o    (vclk[0]),
      .vga_hs_o     (hs[0]),
      .vga_vs_o     (vs[0]),
      .vga_blank_n_o(bl[0]),
      .vga_r_o      (rr[0]),
      .vga_g_o      (gg[0]),
      .vga_b_o      (bb[0]),
      .frame_pulse_o(fp[0])
   );

   vga_scan #(
      .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
      .V_VISIBLE(30), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) u_small (
      .clock        (clock),
      .reset        (reset),
      .hit_ball_i   (hit[1][2]),
      .hit_bar_i    (hit[1][1]),
      .hit_brick_i  (hit[1][0]),
      .next_x_o     (nx[1]),
      .next_y_o     (ny[1]),
      .vga_clk_o    (vclk[1]),
      .vga_hs_o     (hs[1]),
      .vga_vs_o     (vs[1]),
      .vga_blank_n_o(bl[1]),
      .vga_r_o      (rr[1]),
      .vga_g_o      (gg[1]),
      .vga_b_o      (bb[1]),
      .frame_pulse_o(fp[1])
   );

   // Scene: which objects cover (x,y). Mode 0 random, 1 bar box only, 2 all, 3 bar+brick.
   function automatic logic [2:0] scene(input int id, input int x, input int y, input int md);
      int bx0, bx1, by0, by1;
      logic inbox;
      logic [2:0] r;
      bx0 = (id == 0) ? 256 : 10;
      bx1 = (id == 0) ? 384 : 20;
      by0 = (id == 0) ? 456 : 20;
      by1 = (id == 0) ? 472 : 24;
      inbox = (x >= bx0) && (x <= bx1) && (y >= by0) && (y <= by1);
      r = tab[((x * 31) + (y * 17)) & 255];
      case (md)
         0:       return {r[0] & r[2], inbox, r[1]};
         1:       return {1'b0, inbox, 1'b0};
         2:       return 3'b111;
         default: return 3'b011;
      endcase
   endfunction

   assign hit[0] = scene(0, int'(nx[0]), int'(ny[0]), mode);
   assign hit[1] = scene(1, int'(nx[1]), int'(ny[1]), mode);

   // Expected state after the k-th rising edge since reset, from the pixel index alone.
   function automatic logic [48:0] model(input int id, input int k, input int md);
      int ht, vt, hv, vv, hs0, hs1, vs0, vs1;
      int q, p, x, y;
      logic vis, h, v, f;
      logic [2:0] t;
      logic [23:0] c;
      hv = (id == 0) ? 640 : 40;
      vv = (id == 0) ? 480 : 30;
      ht = (id == 0) ? 800 : 58;
      vt = (id == 0) ? 525 : 37;
      hs0 = hv + ((id == 0) ? 16 : 4);
      hs1 = hs0 + ((id == 0) ? 96 : 8) - 1;
      vs0 = vv + 2 + ((id == 0) ? 8 : 0);
      vs1 = vs0 + 1;
      q = k / 2;
      if (k < 2) begin
         return {10'(q % ht), 10'((q / ht) % vt), (k == 1), 1'b1, 1'b1, 1'b0, 24'h0, 1'b0};
      end
      p = q - 1;
      x = p % ht;
      y = (p / ht) % vt;
      vis = (x < hv) && (y < vv);
      h = !((x >= hs0) && (x <= hs1));
      v = !((y >= vs0) && (y <= vs1));
      f = (x == 0) && (y == 0);
      t = scene(id, x, y, md);
      c = !vis ? 24'h000000 : t[2] ? 24'hFFFFFF : t[1] ? 24'h00FFFF : t[0] ? 24'hFF8000
                                                                          : 24'h000000;
      return {10'(q % ht), 10'((q / ht) % vt), 1'b0, h, v, vis, c, f};
   endfunction

   task automatic check(input string nm, input int id, input logic [48:0] got,
                        input logic [48:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, id, $time, got, want);
      end
   endtask

   task automatic check_int(input string nm, input int id, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", nm, id, $time, got, want);
      end
   endtask

   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   // Stimulus side: on each edge push the expected post-edge state of both instances.
   initial begin
      int   k;
      bit   started;
      exp_t e;
      logic [48:0] last [2];
      k = 0;
      started = 0;
      forever begin
         @(posedge clock);
         if (reset) begin
            k = 0;
            started = 1;
         end else if (started) begin
            k++;
         end
         if (started) begin
            for (int id = 0; id < 2; id++) begin
               e.rst = reset;
               if (k >= 2 && (k % 2) == 1) begin
                  e.v = last[id];
                  e.v[28] = 1'b1;
                  e.v[0] = 1'b0;
               end else begin
                  e.v = model(id, k, mode);
               end
               last[id] = e.v;
               if (id == 0) q0.push_back(e);
               else q1.push_back(e);
            end
         end
      end
   end

   // Monitor side: pop and compare every clock, plus run-length checks of sync/blank/frame.
   int nframes = 0;
   initial begin
      exp_t s;
      int   cyc = 0;
      int   hs_run [2] = '{0, 0};
      int   bl_run [2] = '{0, 0};
      int   vs_run = 0;
      int   prev_f = -1;
      int   hs_len [2] = '{192, 16};
      int   bl_len [2] = '{1280, 80};
      forever begin
         @(negedge clock);
         cyc++;
         for (int id = 0; id < 2; id++) begin
            if ((id == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
               s = (id == 0) ? q0.pop_front() : q1.pop_front();
               check("pixel_state", id,
                     {nx[id], ny[id], vclk[id], hs[id], vs[id], bl[id], rr[id], gg[id],
                      bb[id], fp[id]}, s.v);
               if (s.rst) begin
                  hs_run[id] = 0;
                  bl_run[id] = 0;
                  if (id == 1) begin
                     vs_run = 0;
                     prev_f = -1;
                  end
               end else begin
                  if (!hs[id]) hs_run[id]++;
                  else if (hs_run[id] != 0) begin
                     check_int("hs_low_len", id, hs_run[id], hs_len[id]);
                     hs_run[id] = 0;
                  end
                  if (bl[id]) bl_run[id]++;
                  else if (bl_run[id] != 0) begin
                     check_int("blank_high_len", id, bl_run[id], bl_len[id]);
                     bl_run[id] = 0;
                  end
                  if (id == 1) begin
                     if (!vs[1]) vs_run++;
                     else if (vs_run != 0) begin
                        check_int("vs_low_len", 1, vs_run, 232);
                        vs_run = 0;
                     end
                     if (fp[1]) begin
                        nframes++;
                        if (prev_f >= 0) check_int("frame_spacing", 1, cyc - prev_f, 4292);
                        prev_f = cyc;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      mode  = 0;
      for (int i = 0; i < 256; i++) tab[i] = 3'($urandom);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (2 * 4292) @(negedge clock);
      mode = 1;
      repeat (4292) @(negedge clock);
      mode = 2;
      repeat (4292) @(negedge clock);
      mode = 3;
      repeat (4292) @(negedge clock);
      mode = 0;
      repeat (1000 + $urandom_range(0, 50)) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (2000) @(negedge clock);
      repeat (3) @(negedge clock);
      check_int("frames_seen_min", 1, int'(nframes >= 5), 1);
      check_int("queue_drained", 0, q0.size() + q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
